// File: rtl/sum22_arbiter_pkg.sv
// Shared constants and types for the two-requester 22-bit summing arbiter.
package sum22_arbiter_pkg;

  localparam int OPW = 22;

  typedef logic [1:0] kpg_t;
  localparam kpg_t KPG_KILL = 2'b00;
  localparam kpg_t KPG_GEN  = 2'b11;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/sum22bit.sv
// 22-bit adder with kpg-encoded carry-in; bit 22 of sum is the carry-out.
module sum22bit
  import sum22_arbiter_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  kpg_t           cin,
  output logic [OPW:0]   sum
);

  logic carry_in;

  assign carry_in = (cin == KPG_GEN);
  assign sum      = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, carry_in};

endmodule

// File: rtl/sum22_arbiter.sv
// Two-requester arbiter feeding a two-stage (operand, sum) pipeline with
// valid/ready handshakes on both sides.
module sum22_arbiter
  import sum22_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic           req0_cin,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  input  logic           req1_cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW:0]   out_sum,
  output logic           out_id,
  output logic           busy
);

  logic           s1_valid;
  logic [OPW-1:0] s1_a;
  logic [OPW-1:0] s1_b;
  logic           s1_cin;
  req_id_t        s1_id;

  logic           s2_valid;
  logic [OPW:0]   s2_sum;
  req_id_t        s2_id;

  req_id_t        ptr;
  req_id_t        gnt;
  logic           any_req;
  logic           s1_load;
  logic           s2_load;
  logic           xfer;
  logic [OPW:0]   sum;
  kpg_t           s1_kpg;

  // A lone valid requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = REQ0;
    if (req0_valid && req1_valid) begin
      gnt = (RR_EN && (ptr == REQ1)) ? REQ1 : REQ0;
    end else if (req1_valid) begin
      gnt = REQ1;
    end
  end

  assign any_req = req0_valid || req1_valid;
  assign s2_load = !s2_valid || out_ready;
  assign s1_load = !s1_valid || s2_load;
  // NOTE: readies are combinational, so rst must mask them directly to keep
  // them low while reset is held rather than only after the next edge.
  assign xfer       = any_req && s1_load && !rst;
  assign req0_ready = xfer && (gnt == REQ0);
  assign req1_ready = xfer && (gnt == REQ1);

  // NOTE: datapath registers are reset too, so out_sum/out_id read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_id    <= REQ0;
      ptr      <= REQ0;
    end else begin
      if (s1_load) begin
        s1_valid <= any_req;
        if (any_req) begin
          s1_a   <= (gnt == REQ1) ? req1_a   : req0_a;
          s1_b   <= (gnt == REQ1) ? req1_b   : req0_b;
          s1_cin <= (gnt == REQ1) ? req1_cin : req0_cin;
          s1_id  <= gnt;
        end
      end
      if (xfer) begin
        ptr <= (gnt == REQ0) ? REQ1 : REQ0;
      end
    end
  end

  assign s1_kpg = s1_cin ? KPG_GEN : KPG_KILL;

  sum22bit u_add (
    .a   (s1_a),
    .b   (s1_b),
    .cin (s1_kpg),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_id    <= REQ0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum <= sum;
        s2_id  <= s1_id;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_sum   = s2_sum;
  assign out_id    = s2_id;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_sum22_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance on shared inputs.
module tb_sum22_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [21:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        out_ready;

  logic        req0_ready, req1_ready, out_valid, out_id, busy;
  logic [22:0] out_sum;
  logic        fp_req0_ready, fp_req1_ready, fp_out_valid, fp_out_id, fp_busy;
  logic [22:0] fp_out_sum;

  always #5 clk = ~clk;

  sum22_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .busy(busy)
  );

  sum22_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_sum(fp_out_sum), .out_id(fp_out_id), .busy(fp_busy)
  );

  typedef struct {
    logic        id;
    logic [22:0] sum;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt0 = 0, cnt1 = 0, lim0 = 0, lim1 = 0;
  int   tick_no = 0, take_first = -1, take_last = -1, take_cnt = 0;
  logic fire0, fire1;
  logic fp_check = 1'b0;
  logic [22:0] held_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] op_a(input int r, input int k);
    return 22'(k * 32'h12345 + r * 32'h2F00F1) ^ 22'h3FF000;
  endfunction

  function automatic logic [21:0] op_b(input int r, input int k);
    return 22'(k * 32'h0ABCD7 + r * 32'h155555 + 32'h200000);
  endfunction

  function automatic logic op_c(input int r, input int k);
    return 1'((k + r) & 1);
  endfunction

  function automatic exp_t mk_exp(input int r, input int k);
    exp_t e;
    e.id  = 1'(r);
    e.sum = {1'b0, op_a(r, k)} + {1'b0, op_b(r, k)} + {22'd0, op_c(r, k)};
    return e;
  endfunction

  // Drive requesters from their counters, settle, and score any output beat.
  task automatic settle();
    exp_t e;
    req0_valid = (cnt0 < lim0);
    req0_a = op_a(0, cnt0); req0_b = op_b(0, cnt0); req0_cin = op_c(0, cnt0);
    req1_valid = (cnt1 < lim1);
    req1_a = op_a(1, cnt1); req1_b = op_b(1, cnt1); req1_cin = op_c(1, cnt1);
    #1;
    fire0 = req0_valid && req0_ready;
    fire1 = req1_valid && req1_ready;
    check("one_hot_ready", 32'(req0_ready && req1_ready), 32'd0);
    if (fp_check) begin
      check("fp_req0_ready", 32'(fp_req0_ready), 32'd1);
      check("fp_req1_ready", 32'(fp_req1_ready), 32'd0);
      if (fp_out_valid) check("fp_out_id", 32'(fp_out_id), 32'd0);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_id", 32'(out_id), 32'(e.id));
        check("out_sum", 32'(out_sum), 32'(e.sum));
      end
      if (take_first < 0) take_first = tick_no;
      take_last = tick_no;
      take_cnt++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (fire0) cnt0++;
    if (fire1) cnt1++;
    tick_no++;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (q.size() > 0 && guard < 40) begin
      tick();
      guard++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One isolated operation through an empty pipeline with out_ready high.
  task automatic single(input int r, input logic [21:0] a, input logic [21:0] b,
                        input logic c, input logic [22:0] exp_sum);
    out_ready = 1'b1;
    req0_valid = (r == 0); req0_a = a; req0_b = b; req0_cin = c;
    req1_valid = (r == 1); req1_a = a; req1_b = b; req1_cin = c;
    #1;
    check("single_ready0", 32'(req0_ready), 32'(r == 0));
    check("single_ready1", 32'(req1_ready), 32'(r == 1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("single_lat_n", 32'(out_valid), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sum", 32'(out_sum), 32'(exp_sum));
    check("single_id", 32'(out_id), 32'(r));
    @(posedge clk); #1;
    check("single_empty", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    single(0, 22'h3FFFFF, 22'h000001, 1'b0, 23'h400000);
    single(1, 22'h3FFFFF, 22'h3FFFFF, 1'b1, 23'h7FFFFF);

    // Round-robin streaming, both valid every cycle.
    pulse_reset();
    out_ready = 1'b1;
    lim0 = cnt0 + 4; lim1 = cnt1 + 4;
    for (int k = 0; k < 4; k++) begin
      q.push_back(mk_exp(0, cnt0 + k));
      q.push_back(mk_exp(1, cnt1 + k));
    end
    take_first = -1; take_cnt = 0;
    fp_check = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    fp_check = 1'b0;
    drain("rr_drain");
    check("rr_count", 32'(take_cnt), 32'd8);
    check("rr_back_to_back", 32'(take_last - take_first + 1), 32'd8);

    // Streaming with a five-cycle consumer stall.
    lim0 = cnt0 + 3; lim1 = cnt1 + 3;
    for (int k = 0; k < 3; k++) begin
      q.push_back(mk_exp(0, cnt0 + k));
      q.push_back(mk_exp(1, cnt1 + k));
    end
    for (int t = 0; t < 7; t++) begin
      out_ready = (t < 2);
      settle();
      if (t == 3) held_sum = out_sum;
      if (t == 4 || t == 6) begin
        check("stall_ready0", 32'(req0_ready), 32'd0);
        check("stall_ready1", 32'(req1_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
      end
      if (t == 6) check("stall_hold_sum", 32'(out_sum), 32'(held_sum));
      advance();
    end
    out_ready = 1'b1;
    drain("stall_drain");

    // Fill both stages from req0 only (pointer ends at req1), then reset.
    out_ready = 1'b0;
    lim0 = cnt0 + 2; lim1 = cnt1;
    tick();
    tick();
    check("full_busy", 32'(busy), 32'd1);
    check("full_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    lim0 = cnt0 + 1; lim1 = cnt1 + 1;
    q.push_back(mk_exp(0, cnt0));
    q.push_back(mk_exp(1, cnt1));
    settle();
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    advance();
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
